// File: rtl/data_memory_responder_pkg.sv
// rtl/data_memory_responder_pkg.sv - shared widths, opcodes, FSM states and opcode-class helpers
// Purpose: common definitions for the data memory responder and the memory FU decode.
// Contents: DATA_W/RSV_ID_W/INSTR_W/CDB_W widths, I_* opcode encodings,
//           dmem_state_e FSM states, is_load()/is_store() classifiers.
package data_memory_responder_pkg;

  localparam int DATA_W   = 32;
  localparam int RSV_ID_W = 4;
  localparam int INSTR_W  = 8;
  localparam int CDB_W    = RSV_ID_W + DATA_W;

  localparam logic [INSTR_W-1:0] I_LOAD    = 8'h10;
  localparam logic [INSTR_W-1:0] I_LOADB   = 8'h11;
  localparam logic [INSTR_W-1:0] I_LOADR   = 8'h12;
  localparam logic [INSTR_W-1:0] I_LOADT   = 8'h13;
  localparam logic [INSTR_W-1:0] I_LOADTB  = 8'h14;
  localparam logic [INSTR_W-1:0] I_STORE   = 8'h20;
  localparam logic [INSTR_W-1:0] I_STOREB  = 8'h21;
  localparam logic [INSTR_W-1:0] I_STORER  = 8'h22;
  localparam logic [INSTR_W-1:0] I_STORET  = 8'h23;
  localparam logic [INSTR_W-1:0] I_STORETB = 8'h24;
  localparam logic [INSTR_W-1:0] I_INPUT   = 8'h30;
  localparam logic [INSTR_W-1:0] I_OUTPUT  = 8'h31;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    RESP    = 3'd2,
    TX_WAIT = 3'd3,
    RX_WAIT = 3'd4
  } dmem_state_e;

  // Addressing variants are resolved upstream, so every load flavour is one class.
  function automatic logic is_load(input logic [INSTR_W-1:0] op);
    return op inside {I_LOAD, I_LOADB, I_LOADR, I_LOADT, I_LOADTB};
  endfunction

  function automatic logic is_store(input logic [INSTR_W-1:0] op);
    return op inside {I_STORE, I_STOREB, I_STORER, I_STORET, I_STORETB};
  endfunction

endpackage

// File: rtl/data_memory_responder_ram.sv
// rtl/data_memory_responder_ram.sv - single-port data RAM, sync write, 1-cycle sync read
// Purpose: on-chip data memory; read-during-write returns the old word.
// Ports: clk; we/re write and read enables; addr word index; wdata write word;
//        rdata read word, valid the cycle after re. Contents are never reset.
module data_memory_responder_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - memory FU responder: data RAM, byte stream I/O, CDB results
// Purpose: accepts load/store/IO requests, accesses the data RAM or the byte
//   stream, and returns load/input results on the CDB as {rsv_id, data}.
// Optional feature macro: DMEM_RANGE_CHECK_EN (out-of-range address detection).
// Ports: clk, nrst (async active-low); request i_valid/i_opcode/i_rsv_id/
//   i_address/i_data with i_ready; result o_cdb/o_cdb_valid with o_cdb_ready;
//   output stream tx_data/tx_valid/tx_ready; input stream rx_data/rx_valid/
//   rx_ready; o_err one-cycle out-of-range pulse.
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int MEM_ADDR_W = 10,
  parameter int IO_DATA_W  = 8
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 i_valid,
  input  logic [INSTR_W-1:0]   i_opcode,
  input  logic [RSV_ID_W-1:0]  i_rsv_id,
  input  logic [DATA_W-1:0]    i_address,
  input  logic [DATA_W-1:0]    i_data,
  output logic                 i_ready,
  output logic [CDB_W-1:0]     o_cdb,
  output logic                 o_cdb_valid,
  input  logic                 o_cdb_ready,
  output logic [IO_DATA_W-1:0] tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  input  logic [IO_DATA_W-1:0] rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  output logic                 o_err
);

  dmem_state_e state_q, state_d;

  logic                 accept;
  logic                 op_load;
  logic                 op_store;
  logic                 oor;
  logic                 ram_we;
  logic                 ram_re;
  logic [DATA_W-1:0]    ram_rdata;
  logic [RSV_ID_W-1:0]  rsv_q;
  logic                 oor_q;
  logic [CDB_W-1:0]     cdb_q;
  logic                 cdb_valid_q;
  logic [IO_DATA_W-1:0] tx_data_q;
  logic                 tx_valid_q;

  assign op_load  = is_load(i_opcode);
  assign op_store = is_store(i_opcode);
  assign accept   = i_valid & i_ready;

`ifdef DMEM_RANGE_CHECK_EN
  assign oor = |i_address[DATA_W-1:MEM_ADDR_W];
`else
  // Upper address bits alias modulo the RAM depth.
  logic unused_addr_hi;
  assign unused_addr_hi = ^i_address[DATA_W-1:MEM_ADDR_W];
  assign oor = 1'b0;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    // nrst gating keeps i_ready low while reset is held even though state is IDLE.
    i_ready  = nrst && (state_q == IDLE);
    rx_ready = (state_q == RX_WAIT);
    ram_we   = 1'b0;
    ram_re   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (op_store) begin
            ram_we = !oor;
          end else if (op_load) begin
            ram_re  = 1'b1;
            state_d = RD;
          end else if (i_opcode == I_OUTPUT) begin
            state_d = TX_WAIT;
          end else if (i_opcode == I_INPUT) begin
            state_d = RX_WAIT;
          end
        end
      end
      RD:      state_d = RESP;
      RESP:    if (o_cdb_ready) state_d = IDLE;
      TX_WAIT: if (tx_ready) state_d = IDLE;
      RX_WAIT: if (rx_valid) state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rsv_q       <= '0;
      oor_q       <= 1'b0;
      cdb_q       <= '0;
      cdb_valid_q <= 1'b0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept && (op_load || i_opcode == I_INPUT)) begin
            rsv_q <= i_rsv_id;
            oor_q <= oor && op_load;
          end
          if (accept && !op_load && !op_store && i_opcode == I_OUTPUT) begin
            tx_data_q  <= i_data[IO_DATA_W-1:0];
            tx_valid_q <= 1'b1;
          end
        end
        RD: begin
          // An out-of-range load keeps its latency but returns zero.
          cdb_q       <= {rsv_q, (oor_q ? {DATA_W{1'b0}} : ram_rdata)};
          cdb_valid_q <= 1'b1;
        end
        RESP: begin
          if (o_cdb_ready) begin
            cdb_valid_q <= 1'b0;
          end
        end
        TX_WAIT: begin
          if (tx_ready) begin
            tx_valid_q <= 1'b0;
          end
        end
        RX_WAIT: begin
          if (rx_valid) begin
            cdb_q       <= {rsv_q, {(DATA_W-IO_DATA_W){1'b0}}, rx_data};
            cdb_valid_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DMEM_RANGE_CHECK_EN
  logic err_q;
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= accept && oor && (op_load || op_store);
    end
  end
  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

  assign o_cdb       = cdb_q;
  assign o_cdb_valid = cdb_valid_q;
  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;

  data_memory_responder_ram #(
    .ADDR_W(MEM_ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .re   (ram_re),
    .addr (i_address[MEM_ADDR_W-1:0]),
    .wdata(i_data),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_data_memory_responder.sv
// tb/tb_data_memory_responder.sv - self-checking bench for data_memory_responder
module tb_data_memory_responder;
  import data_memory_responder_pkg::*;

  localparam int MEM_ADDR_W = 10;
  localparam int IO_DATA_W  = 8;

  logic                 clk = 1'b0;
  logic                 nrst;
  logic                 i_valid;
  logic [INSTR_W-1:0]   i_opcode;
  logic [RSV_ID_W-1:0]  i_rsv_id;
  logic [DATA_W-1:0]    i_address;
  logic [DATA_W-1:0]    i_data;
  logic                 i_ready;
  logic [CDB_W-1:0]     o_cdb;
  logic                 o_cdb_valid;
  logic                 o_cdb_ready;
  logic [IO_DATA_W-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [IO_DATA_W-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 o_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tx_hs = 0;
  int rx_hs = 0;
  int cdb_cyc = 0;

  logic [CDB_W-1:0]     sb[$];
  logic [IO_DATA_W-1:0] tx_sb[$];
  logic [DATA_W-1:0]    model_mem [int];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (tx_valid && tx_ready) tx_hs++;
    if (rx_valid && rx_ready) rx_hs++;
    if (o_cdb_valid) cdb_cyc++;
  end

  data_memory_responder #(
    .MEM_ADDR_W(MEM_ADDR_W),
    .IO_DATA_W (IO_DATA_W)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .i_valid    (i_valid),
    .i_opcode   (i_opcode),
    .i_rsv_id   (i_rsv_id),
    .i_address  (i_address),
    .i_data     (i_data),
    .i_ready    (i_ready),
    .o_cdb      (o_cdb),
    .o_cdb_valid(o_cdb_valid),
    .o_cdb_ready(o_cdb_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .o_err      (o_err)
  );

  // Presents one request and returns 1 time unit after its accept edge.
  task automatic issue(input logic [INSTR_W-1:0] op, input logic [RSV_ID_W-1:0] tag,
                       input logic [DATA_W-1:0] addr, input logic [DATA_W-1:0] data);
    int n = 0;
    i_valid   = 1'b1;
    i_opcode  = op;
    i_rsv_id  = tag;
    i_address = addr;
    i_data    = data;
    while (!i_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (i_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: i_ready=%0b required 1", i_ready);
    end
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic wait_cdb(output bit ok);
    int n = 0;
    while (!o_cdb_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    ok = (o_cdb_valid === 1'b1);
  endtask

  task automatic pop_cdb();
    o_cdb_ready = 1'b1;
    @(posedge clk); #1;
    o_cdb_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (i_ready !== 1'b0 || o_cdb_valid !== 1'b0 || o_cdb !== '0 || tx_valid !== 1'b0 ||
        tx_data !== '0 || rx_ready !== 1'b0 || o_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: i_ready=%0b cdb_valid=%0b cdb=%h tx_valid=%0b tx_data=%h rx_ready=%0b err=%0b required all 0",
               i_ready, o_cdb_valid, o_cdb, tx_valid, tx_data, rx_ready, o_err);
    end
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (i_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: i_ready=%0b required 1", i_ready);
    end
  endtask

  task automatic test_store_load();
    logic [CDB_W-1:0] exp;
    model_mem[32'h10] = 32'hDEADBEEF;
    issue(I_STORE, 4'd3, 32'h10, 32'hDEADBEEF);
    sb.push_back({4'd5, model_mem[32'h10]});
    issue(I_LOAD, 4'd5, 32'h10, 32'h0);
    checks++;
    if (o_cdb_valid !== 1'b0) begin
      errors++;
      $display("FAIL load_latency_early: o_cdb_valid=%0b required 0 after accept edge", o_cdb_valid);
    end
    @(posedge clk); #1;
    exp = sb.pop_front();
    checks++;
    if (o_cdb_valid !== 1'b1 || o_cdb !== exp) begin
      errors++;
      $display("FAIL store_load_cdb: valid=%0b cdb=%h required 1 %h", o_cdb_valid, o_cdb, exp);
    end
    pop_cdb();
    checks++;
    if (i_ready !== 1'b1 || o_cdb_valid !== 1'b0) begin
      errors++;
      $display("FAIL store_load_release: i_ready=%0b valid=%0b required 1 0", i_ready, o_cdb_valid);
    end
  endtask

  task automatic test_stall();
    logic [CDB_W-1:0] exp;
    bit ok;
    model_mem[32'h22] = 32'h12345678;
    issue(I_STOREB, 4'd1, 32'h22, 32'h12345678);
    sb.push_back({4'd7, model_mem[32'h22]});
    issue(I_LOADT, 4'd7, 32'h22, 32'h0);
    wait_cdb(ok);
    exp = sb.pop_front();
    checks++;
    if (!ok || o_cdb !== exp) begin
      errors++;
      $display("FAIL stall_first: valid=%0b cdb=%h required 1 %h", ok, o_cdb, exp);
    end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      checks++;
      if (o_cdb_valid !== 1'b1 || o_cdb !== exp || i_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: valid=%0b cdb=%h i_ready=%0b required 1 %h 0",
                 k, o_cdb_valid, o_cdb, i_ready, exp);
      end
    end
    pop_cdb();
    checks++;
    if (i_ready !== 1'b1 || o_cdb_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: i_ready=%0b valid=%0b required 1 0", i_ready, o_cdb_valid);
    end
  endtask

  task automatic test_output();
    logic [IO_DATA_W-1:0] exp;
    int hs0;
    int c0;
    hs0 = tx_hs;
    c0 = cdb_cyc;
    tx_ready = 1'b0;
    tx_sb.push_back(8'h41);
    issue(I_OUTPUT, 4'd0, 32'h0, 32'h141);
    exp = tx_sb.pop_front();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp || o_cdb_valid !== 1'b0) begin
        errors++;
        $display("FAIL tx_hold[%0d]: tx_valid=%0b tx_data=%h cdb_valid=%0b required 1 %h 0",
                 k, tx_valid, tx_data, o_cdb_valid, exp);
      end
      @(posedge clk); #1;
    end
    tx_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    checks++;
    if (tx_hs - hs0 != 1 || tx_valid !== 1'b0 || cdb_cyc != c0) begin
      errors++;
      $display("FAIL tx_handshake: handshakes=%0d tx_valid=%0b cdb_cycles=%0d required 1 0 0",
               tx_hs - hs0, tx_valid, cdb_cyc - c0);
    end
  endtask

  task automatic test_input();
    logic [CDB_W-1:0] exp;
    bit ok;
    int rx0;
    rx0 = rx_hs;
    issue(I_INPUT, 4'd2, 32'h0, 32'h0);
    sb.push_back({4'd2, 32'h0000007A});
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (rx_ready !== 1'b1 || o_cdb_valid !== 1'b0) begin
        errors++;
        $display("FAIL rx_wait[%0d]: rx_ready=%0b cdb_valid=%0b required 1 0", k, rx_ready, o_cdb_valid);
      end
      @(posedge clk); #1;
    end
    rx_data  = 8'h7A;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = 8'hFF;
    checks++;
    if (rx_hs - rx0 != 1 || rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL rx_handshake: handshakes=%0d rx_ready=%0b required 1 0", rx_hs - rx0, rx_ready);
    end
    wait_cdb(ok);
    exp = sb.pop_front();
    checks++;
    if (!ok || o_cdb !== exp) begin
      errors++;
      $display("FAIL input_cdb: valid=%0b cdb=%h required 1 %h", ok, o_cdb, exp);
    end
    pop_cdb();
  endtask

  task automatic test_back_to_back();
    logic [CDB_W-1:0] exp;
    bit ok;
    int c0;
    logic [DATA_W-1:0] d;
    logic [INSTR_W-1:0] st_ops[4];
    logic [INSTR_W-1:0] ld_ops[4];
    st_ops = '{I_STORE, I_STORER, I_STORET, I_STORETB};
    ld_ops = '{I_LOADB, I_LOADR, I_LOADTB, I_LOAD};
    c0 = cyc;
    for (int k = 0; k < 4; k++) begin
      d = $urandom;
      model_mem[32'h40 + k] = d;
      issue(st_ops[k], 4'(k), 32'h40 + k, d);
    end
    checks++;
    if (cyc - c0 != 4) begin
      errors++;
      $display("FAIL store_rate: cycles=%0d required 4", cyc - c0);
    end
    for (int k = 0; k < 4; k++) begin
      sb.push_back({4'(8 + k), model_mem[32'h40 + k]});
      issue(ld_ops[k], 4'(8 + k), 32'h40 + k, 32'h0);
      wait_cdb(ok);
      exp = sb.pop_front();
      checks++;
      if (!ok || o_cdb !== exp) begin
        errors++;
        $display("FAIL b2b_load[%0d]: valid=%0b cdb=%h required 1 %h", k, ok, o_cdb, exp);
      end
      pop_cdb();
    end
  endtask

  task automatic test_unknown();
    int c0;
    c0 = cdb_cyc;
    issue(8'hFF, 4'd4, 32'h10, 32'h55);
    checks++;
    if (i_ready !== 1'b1 || tx_valid !== 1'b0 || rx_ready !== 1'b0 || o_err !== 1'b0) begin
      errors++;
      $display("FAIL unknown_op: i_ready=%0b tx_valid=%0b rx_ready=%0b err=%0b required 1 0 0 0",
               i_ready, tx_valid, rx_ready, o_err);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (cdb_cyc != c0) begin
      errors++;
      $display("FAIL unknown_no_cdb: cdb_cycles=%0d required 0", cdb_cyc - c0);
    end
  endtask

  task automatic test_reset_mid_rd();
    int c0;
    issue(I_LOAD, 4'd6, 32'h10, 32'h0);
    nrst = 1'b0;
    #1;
    checks++;
    if (i_ready !== 1'b0 || o_cdb_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_rd: i_ready=%0b valid=%0b required 0 0", i_ready, o_cdb_valid);
    end
    #1;
    nrst = 1'b1;
    c0 = cdb_cyc;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (cdb_cyc != c0 || i_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_drop: cdb_cycles=%0d i_ready=%0b required 0 1", cdb_cyc - c0, i_ready);
    end
  endtask

  task automatic test_range();
    logic [CDB_W-1:0] exp;
    bit ok;
`ifdef DMEM_RANGE_CHECK_EN
    issue(I_STORE, 4'd1, 32'h400 + 32'h10, 32'hCAFEF00D);
    checks++;
    if (o_err !== 1'b1) begin
      errors++;
      $display("FAIL range_store_err: o_err=%0b required 1", o_err);
    end
    @(posedge clk); #1;
    checks++;
    if (o_err !== 1'b0) begin
      errors++;
      $display("FAIL range_err_pulse: o_err=%0b required 0", o_err);
    end
    sb.push_back({4'd9, 32'h0});
    issue(I_LOAD, 4'd9, 32'h400, 32'h0);
    checks++;
    if (o_err !== 1'b1) begin
      errors++;
      $display("FAIL range_load_err: o_err=%0b required 1", o_err);
    end
    @(posedge clk); #1;
    exp = sb.pop_front();
    checks++;
    if (o_cdb_valid !== 1'b1 || o_cdb !== exp) begin
      errors++;
      $display("FAIL range_load_cdb: valid=%0b cdb=%h required 1 %h", o_cdb_valid, o_cdb, exp);
    end
    pop_cdb();
`else
    model_mem[32'h30] = 32'hCAFEF00D;
    issue(I_STORE, 4'd1, 32'h400 + 32'h30, 32'hCAFEF00D);
    checks++;
    if (o_err !== 1'b0) begin
      errors++;
      $display("FAIL alias_err: o_err=%0b required 0", o_err);
    end
`endif
    sb.push_back({4'd10, model_mem[32'h10]});
    issue(I_LOAD, 4'd10, 32'h10, 32'h0);
    wait_cdb(ok);
    exp = sb.pop_front();
    checks++;
    if (!ok || o_cdb !== exp) begin
      errors++;
      $display("FAIL range_inrange_0x10: valid=%0b cdb=%h required 1 %h", ok, o_cdb, exp);
    end
    pop_cdb();
`ifndef DMEM_RANGE_CHECK_EN
    sb.push_back({4'd11, model_mem[32'h30]});
    issue(I_LOAD, 4'd11, 32'h30, 32'h0);
    wait_cdb(ok);
    exp = sb.pop_front();
    checks++;
    if (!ok || o_cdb !== exp) begin
      errors++;
      $display("FAIL alias_load: valid=%0b cdb=%h required 1 %h", ok, o_cdb, exp);
    end
    pop_cdb();
`endif
  endtask

  initial begin
    nrst        = 1'b0;
    i_valid     = 1'b0;
    i_opcode    = '0;
    i_rsv_id    = '0;
    i_address   = '0;
    i_data      = '0;
    o_cdb_ready = 1'b0;
    tx_ready    = 1'b0;
    rx_data     = '0;
    rx_valid    = 1'b0;
    test_reset();
    test_store_load();
    test_stall();
    test_output();
    test_input();
    test_back_to_back();
    test_unknown();
    test_reset_mid_rd();
    test_range();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
